// File: rtl/sr_pkg.sv
// Shared types and default timing constants for the srlatch driver.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE_S,
    PULSE_R,
    GAP
  } sr_state_t;

  localparam int DEB_CYCLES_DEF   = 4;
  localparam int PULSE_CYCLES_DEF = 3;
  localparam int GAP_CYCLES_DEF   = 2;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer, debounce counter and rising-edge detect for one raw request line.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The count reaching DEB_CYCLES flips the level and restarts the count in one step.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == DEB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Taken from the next level so the pending bit is set on the same edge deb rises.
  assign rise = deb_d & ~deb_q;

endmodule

// File: rtl/sr_drive.sv
// Latch driver: debounced set/reset requests become non-overlapping s/r pulses with
// a trailing idle gap, plus a registered model of the latch output.
module sr_drive
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic rst_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic q_model,
  output logic conflict
);

  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] P_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] G_LAST = TW'(GAP_CYCLES - 1);

  logic rise_s;
  logic rise_r;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (set_in),
    .rise  (rise_s)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rst_in),
    .rise  (rise_r)
  );

  sr_state_t     state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          pend_s_q, pend_s_d;
  logic          pend_r_q, pend_r_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          busy_q, busy_d;
  logic          q_model_q, q_model_d;
  logic          conflict_q, conflict_d;
  logic          take_s;
  logic          take_r;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    q_model_d = q_model_q;
    take_s    = 1'b0;
    take_r    = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (pend_s_q) begin
          state_d = PULSE_S;
          take_s  = 1'b1;
        end else if (pend_r_q) begin
          state_d = PULSE_R;
          take_r  = 1'b1;
        end
      end
      PULSE_S, PULSE_R: begin
        if (tmr_q == P_LAST) begin
          state_d   = GAP;
          tmr_d     = '0;
          q_model_d = (state_q == PULSE_S);
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      GAP: begin
        if (tmr_q == G_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase

    // Simultaneous edges cancel each other; otherwise the newest request replaces the other kind.
    pend_s_d   = pend_s_q & ~take_s;
    pend_r_d   = pend_r_q & ~take_r;
    conflict_d = 1'b0;
    if (rise_s && rise_r) begin
      conflict_d = 1'b1;
    end else if (rise_s) begin
      pend_s_d = 1'b1;
      pend_r_d = 1'b0;
    end else if (rise_r) begin
      pend_r_d = 1'b1;
      pend_s_d = 1'b0;
    end

    s_d    = (state_d == PULSE_S);
    r_d    = (state_d == PULSE_R);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      q_model_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      q_model_q  <= q_model_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign q_model  = q_model_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_drive.sv
// Directed and random stimulus for sr_drive, checked each cycle against a timeline-based reference model.
module tb_sr_drive;

  localparam int DEB = 4;
  localparam int P   = 3;
  localparam int G   = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic set_in;
  logic rst_in;
  logic s;
  logic r;
  logic busy;
  logic q_model;
  logic conflict;

  sr_drive #(
    .DEB_CYCLES   (DEB),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_in   (set_in),
    .rst_in   (rst_in),
    .s        (s),
    .r        (r),
    .busy     (busy),
    .q_model  (q_model),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw sample history plus a pulse timeline (start edge and kind).
  int  e;
  bit  hs[$];
  bit  hr[$];
  bit  m_deb_s, m_deb_r;
  int  pend;       // 0 none, 1 set, 2 reset
  bit  active;
  int  start;
  int  kind;
  bit  q_prev;
  int  n_txn = 0;
  bit  exp_s, exp_r, exp_busy, exp_q, exp_conf;

  function automatic bit raw_at(input bit is_set, input int idx);
    if (idx < 0) return 1'b0;
    return is_set ? hs[idx] : hr[idx];
  endfunction

  // The level changes once the last DEB synchronized samples all disagree with it.
  function automatic bit window_differs(input bit is_set, input bit level);
    for (int j = 0; j < DEB; j++) begin
      if (raw_at(is_set, e - 2 - j) == level) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    e = 0;
    hs.delete();
    hr.delete();
    m_deb_s = 1'b0;
    m_deb_r = 1'b0;
    pend    = 0;
    active  = 1'b0;
    start   = 0;
    kind    = 0;
    q_prev  = 1'b0;
  endtask

  task automatic model_step();
    bit rs, rr;
    hs.push_back(set_in);
    hr.push_back(rst_in);
    rs = 1'b0;
    rr = 1'b0;
    if (window_differs(1'b1, m_deb_s)) begin
      m_deb_s = ~m_deb_s;
      rs = m_deb_s;
    end
    if (window_differs(1'b0, m_deb_r)) begin
      m_deb_r = ~m_deb_r;
      rr = m_deb_r;
    end
    if ((!active || (e - 1 >= start + P + G)) && pend != 0) begin
      if (active) q_prev = (kind == 1);
      active = 1'b1;
      start  = e;
      kind   = pend;
      pend   = 0;
      n_txn++;
      $display("txn %0d: %s pulse starts at edge %0d", n_txn, (kind == 1) ? "set" : "reset", e);
    end
    exp_conf = rs && rr;
    if (!exp_conf) begin
      if (rs) pend = 1;
      else if (rr) pend = 2;
    end
    exp_s    = active && kind == 1 && e < start + P;
    exp_r    = active && kind == 2 && e < start + P;
    exp_busy = active && e < start + P + G;
    exp_q    = (active && e >= start + P) ? (kind == 1) : q_prev;
    e++;
  endtask

  task automatic cycle(input bit sv, input bit rv);
    set_in = sv;
    rst_in = rv;
    @(posedge clk);
    model_step();
    #1;
    check_eq("s", s, exp_s);
    check_eq("r", r, exp_r);
    check_eq("busy", busy, exp_busy);
    check_eq("q_model", q_model, exp_q);
    check_eq("conflict", conflict, exp_conf);
    check_eq("s_r_exclusive", s & r, 1'b0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    set_in = 1'b0;
    rst_in = 1'b0;
    @(posedge clk);
    #2;
    check_eq("rst_s", s, 1'b0);
    check_eq("rst_r", r, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_q_model", q_model, 1'b0);
    check_eq("rst_conflict", conflict, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n_conf;
    int hold_s, hold_r;
    bit lv_s, lv_r;
    bit reached;

    // Held set: s on edges 6-8, gap 9-10, idle from 11.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b0);
      check_eq("t1_s_timing", s, (i >= 6 && i <= 8));
      check_eq("t1_busy_timing", busy, (i >= 6 && i <= 10));
      check_eq("t1_q_timing", q_model, (i >= 9));
    end

    // Short glitch on rst_in is filtered.
    do_reset();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0);
      check_eq("t2_r_quiet", r, 1'b0);
      check_eq("t2_busy_quiet", busy, 1'b0);
    end

    // Simultaneous rise: one conflict pulse, no drive.
    do_reset();
    n_conf = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b1);
      if (conflict) n_conf++;
      check_eq("t3_s_quiet", s, 1'b0);
      check_eq("t3_r_quiet", r, 1'b0);
      check_eq("t3_q_hold", q_model, 1'b0);
    end
    check_eq("t3_conflict_count", n_conf, 1);

    // Set then reset during the set pulse: both served in order.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1);
    check_eq("t4_q_final", q_model, 1'b0);

    // Interleaved set/reset/set edges while busy; the latest request wins.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);

    // Asynchronous reset during PULSE_R with a set request pending.
    do_reset();
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      cycle((i >= 2), 1'b1);
      reached = exp_r && (pend == 1);
    end
    check_eq("t6_reached_pulse_r", reached, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_s", s, 1'b0);
    check_eq("t6_async_r", r, 1'b0);
    check_eq("t6_async_busy", busy, 1'b0);
    check_eq("t6_async_q", q_model, 1'b0);
    set_in = 1'b0;
    rst_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'b0);
      check_eq("t6_pending_lost", busy, 1'b0);
    end

    // Random levels with random hold times: glitches, real edges, overlaps.
    do_reset();
    hold_s = 0;
    hold_r = 0;
    lv_s   = 1'b0;
    lv_r   = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (hold_s == 0) begin
        lv_s   = 1'($urandom_range(0, 1));
        hold_s = int'($urandom_range(1, 10));
      end
      if (hold_r == 0) begin
        lv_r   = 1'($urandom_range(0, 1));
        hold_r = int'($urandom_range(1, 10));
      end
      hold_s--;
      hold_r--;
      cycle(lv_s, lv_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
